// File: rtl/lsu_pkg.sv
// Shared types for the data-memory load/store unit.
//   lsu_size_e  : access size encoding (B/H/W/D)
//   lsu_state_e : LSU control states
//   size_bytes  : byte count N for a given access size
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } lsu_size_e;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LD_ISSUE = 3'd1,
      LD_WAIT  = 3'd2,
      ST_ISSUE = 3'd3,
      ST_WAIT  = 3'd4,
      RESP     = 3'd5
   } lsu_state_e;

   function automatic logic [3:0] size_bytes(input lsu_size_e size);
      case (size)
         SZ_B:    return 4'd1;
         SZ_H:    return 4'd2;
         SZ_W:    return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational sign/zero extension of an assembled little-endian load word.
//   i_acc    : assembled load bytes, byte i in bits [8i+7:8i]
//   i_size   : access size (B/H/W/D)
//   i_signed : 1 = replicate the top loaded bit, 0 = zero fill
//   o_rdata  : extended result; size D passes through unchanged
module lsu_load_extend
   import lsu_pkg::*;
#(
   parameter int unsigned FETCH_WIDTH = 64
) (
   input  logic [FETCH_WIDTH-1:0] i_acc,
   input  lsu_size_e              i_size,
   input  logic                   i_signed,
   output logic [FETCH_WIDTH-1:0] o_rdata
);

   logic w_fill;

   always_comb begin
      w_fill  = 1'b0;
      o_rdata = i_acc;
      case (i_size)
         SZ_B: begin
            w_fill  = i_signed & i_acc[7];
            o_rdata = {{(FETCH_WIDTH-8){w_fill}}, i_acc[7:0]};
         end
         SZ_H: begin
            w_fill  = i_signed & i_acc[15];
            o_rdata = {{(FETCH_WIDTH-16){w_fill}}, i_acc[15:0]};
         end
         SZ_W: begin
            w_fill  = i_signed & i_acc[31];
            o_rdata = {{(FETCH_WIDTH-32){w_fill}}, i_acc[31:0]};
         end
         default: o_rdata = i_acc;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving the byte-serial data-memory handshake.
// One CPU request at a time; loads are assembled from single-byte reads,
// stores are issued as one multi-byte write.
//   clk, rst          : clock, synchronous active-low reset
//   req_*             : CPU request (valid/ready, store, size, signed, addr, wdata)
//   resp_*            : one-cycle completion pulse with load data and range error
//   mem_*_o           : memory enables, byte address, write size (N-1), write data
//   mem_busy_i/rdy_i  : memory status; mem_rd_data_i[7:0] is the read byte
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned  DATA_WIDTH      = 64,
   parameter int unsigned  FETCH_WIDTH     = 64,
   parameter logic [63:0]  DMEM_SIZE_BYTES = 64'h10000,
   localparam int unsigned SZW             = $clog2(FETCH_WIDTH/8)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic                   req_store_i,
   input  logic [1:0]             req_size_i,
   input  logic                   req_signed_i,
   input  logic [DATA_WIDTH-1:0]  req_addr_i,
   input  logic [FETCH_WIDTH-1:0] req_wdata_i,
   output logic                   resp_valid_o,
   output logic [FETCH_WIDTH-1:0] resp_rdata_o,
   output logic                   resp_err_o,
   output logic                   mem_rd_en_o,
   output logic                   mem_wr_en_o,
   output logic [DATA_WIDTH-1:0]  mem_addr_o,
   output logic [SZW-1:0]         mem_wr_size_o,
   output logic [FETCH_WIDTH-1:0] mem_wr_data_o,
   input  logic                   mem_busy_i,
   input  logic                   mem_rdy_i,
   input  logic [FETCH_WIDTH-1:0] mem_rd_data_i
);

   localparam logic [DATA_WIDTH:0] LP_LIMIT = (DATA_WIDTH+1)'(DMEM_SIZE_BYTES);
   localparam logic [DATA_WIDTH:0] LP_ONE   = 1;

   lsu_state_e             r_state, w_state_nxt;
   logic [SZW-1:0]         r_cnt;
   logic [FETCH_WIDTH-1:0] r_acc;
   logic                   r_store, r_err;
   logic [DATA_WIDTH-1:0]  r_addr;
   lsu_size_e              r_size;
   logic                   r_signed;
   logic [FETCH_WIDTH-1:0] r_wdata;

   lsu_size_e              w_req_size;
   logic [3:0]             w_req_n, w_cur_n, w_cur_n_m1;
   logic [DATA_WIDTH:0]    w_end;
   logic                   w_range_err, w_ready, w_accept, w_last_byte;
   logic [FETCH_WIDTH-1:0] w_ext;
   logic                   w_unused;

   // Only the low byte of the read bus carries data.
   assign w_unused = ^mem_rd_data_i[FETCH_WIDTH-1:8];

   // Last byte address computed one bit wider so an address near the top of
   // the address space cannot wrap back into the legal range.
   assign w_req_size  = lsu_size_e'(req_size_i);
   assign w_req_n     = size_bytes(w_req_size);
   assign w_end       = {1'b0, req_addr_i} + {{(DATA_WIDTH-3){1'b0}}, w_req_n} - LP_ONE;
   assign w_range_err = (w_end >= LP_LIMIT);

   // Ready is forced low while reset is held.
   assign w_ready     = (r_state == IDLE) && rst;
   assign w_accept    = req_valid_i && w_ready;
   assign req_ready_o = w_ready;

   assign w_cur_n     = size_bytes(r_size);
   assign w_cur_n_m1  = w_cur_n - 4'd1;
   assign w_last_byte = (r_cnt == w_cur_n_m1[SZW-1:0]);

   lsu_load_extend #(.FETCH_WIDTH(FETCH_WIDTH)) u_ext (
      .i_acc   (r_acc),
      .i_size  (r_size),
      .i_signed(r_signed),
      .o_rdata (w_ext)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_store <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_store <= req_store_i;
            r_err   <= w_range_err;
         end else if (r_state == LD_WAIT && mem_rdy_i) begin
            r_acc[{r_cnt, 3'b000} +: 8] <= mem_rd_data_i[7:0];
            r_cnt                       <= r_cnt + SZW'(1);
         end
      end
   end

   // Request payload is only consumed in states entered after an accept.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr   <= req_addr_i;
         r_size   <= w_req_size;
         r_signed <= req_signed_i;
         r_wdata  <= req_wdata_i;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      mem_rd_en_o   = 1'b0;
      mem_wr_en_o   = 1'b0;
      mem_addr_o    = '0;
      mem_wr_size_o = '0;
      mem_wr_data_o = '0;
      resp_valid_o  = 1'b0;
      resp_rdata_o  = '0;
      resp_err_o    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_range_err)      w_state_nxt = RESP;
               else if (req_store_i) w_state_nxt = ST_ISSUE;
               else                  w_state_nxt = LD_ISSUE;
            end
         end
         LD_ISSUE: begin
            mem_rd_en_o = !mem_busy_i && rst;
            mem_addr_o  = r_addr + {{(DATA_WIDTH-SZW){1'b0}}, r_cnt};
            if (!mem_busy_i) w_state_nxt = LD_WAIT;
         end
         LD_WAIT: begin
            if (mem_rdy_i) w_state_nxt = w_last_byte ? RESP : LD_ISSUE;
         end
         ST_ISSUE: begin
            mem_wr_en_o   = !mem_busy_i && rst;
            mem_addr_o    = r_addr;
            mem_wr_size_o = w_cur_n_m1[SZW-1:0];
            mem_wr_data_o = r_wdata;
            if (!mem_busy_i) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rdy_i) w_state_nxt = RESP;
         end
         RESP: begin
            resp_valid_o = 1'b1;
            resp_err_o   = r_err;
            resp_rdata_o = (r_err || r_store) ? '0 : w_ext;
            w_state_nxt  = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: behavioural byte memory, reference byte image and
// response model derived from the access rules, plus literal expectations.
module tb_dmem_lsu;

   localparam logic [63:0] DMEM_SIZE = 64'h10000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid_i = 1'b0, req_store_i = 1'b0, req_signed_i = 1'b0;
   logic [1:0]  req_size_i = 2'd0;
   logic [63:0] req_addr_i = '0, req_wdata_i = '0;
   logic        req_ready_o, resp_valid_o, resp_err_o;
   logic [63:0] resp_rdata_o;
   logic        mem_rd_en_o, mem_wr_en_o;
   logic [63:0] mem_addr_o, mem_wr_data_o, mem_rd_data_i;
   logic [2:0]  mem_wr_size_o;
   logic        mem_busy_i, mem_rdy_i;

   dmem_lsu #(.DATA_WIDTH(64), .FETCH_WIDTH(64), .DMEM_SIZE_BYTES(DMEM_SIZE)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
      .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
      .resp_err_o(resp_err_o), .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
      .mem_addr_o(mem_addr_o), .mem_wr_size_o(mem_wr_size_o), .mem_wr_data_o(mem_wr_data_o),
      .mem_busy_i(mem_busy_i), .mem_rdy_i(mem_rdy_i), .mem_rd_data_i(mem_rd_data_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural memory ----------------
   logic [7:0]  dmem [0:65535];
   logic [7:0]  rd_byte = 8'h00;
   int          phase = 0;
   int          rd_extra = 0;
   logic        pl_en = 1'b0;
   logic [15:0] pl_addr = '0;
   logic [7:0]  pl_data = '0;

   always @(posedge clk) begin
      if (pl_en) dmem[pl_addr] <= pl_data;
      if (mem_rd_en_o) begin
         phase   <= 2 + rd_extra;
         rd_byte <= dmem[mem_addr_o[15:0]];
      end else if (mem_wr_en_o) begin
         phase <= int'(mem_wr_size_o) + 2;
         for (int i = 0; i < 8; i++)
            if (i <= int'(mem_wr_size_o))
               dmem[mem_addr_o[15:0] + 16'(i)] <= mem_wr_data_o[8*i +: 8];
      end else if (phase > 0) begin
         phase <= phase - 1;
      end
   end

   assign mem_busy_i    = (phase != 0);
   assign mem_rdy_i     = (phase == 1);
   assign mem_rd_data_i = {56'hA5A5_A5A5_A5A5_A5, rd_byte};

   // ---------------- reference model ----------------
   typedef struct { int cyc; logic [63:0] data; logic err; } exp_t;
   typedef struct { int cyc; logic [63:0] addr; } rd_t;
   typedef struct { logic [63:0] addr; logic [2:0] size; logic [63:0] data; } wr_t;

   logic [7:0] ref_mem [0:65535];
   exp_t exp_q [$];
   rd_t  rd_log [$];
   wr_t  wr_log [$];
   logic [63:0] last_rdata;
   logic        last_err;
   int          last_cyc;

   function automatic exp_t model(input bit st, input int sz, input bit sg,
                                  input logic [63:0] addr, input bit idle);
      exp_t e;
      int n, sh;
      logic [63:0] w;
      logic [15:0] ix;
      n      = 1 << sz;
      e.err  = (addr > DMEM_SIZE - 64'(n));
      e.data = '0;
      if (e.err)      e.cyc = 1;
      else if (!idle) e.cyc = -1;
      else            e.cyc = st ? n + 3 : 3 * n + 1;
      if (!e.err && !st) begin
         w = '0;
         for (int i = 0; i < n; i++) begin
            ix = 16'(addr + 64'(i));
            w  = w | (64'(ref_mem[ix]) << (8 * i));
         end
         sh     = 64 - 8 * n;
         e.data = (sg && n < 8) ? 64'($signed(w << sh) >>> sh) : w;
      end
      return e;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (mem_rd_en_o || mem_wr_en_o) begin
         chk("en_while_busy", 64'(mem_busy_i), 64'd0);
         chk("en_overlap", 64'(mem_rd_en_o && mem_wr_en_o), 64'd0);
         if (mem_rd_en_o) rd_log.push_back('{cyc, mem_addr_o});
         if (mem_wr_en_o) wr_log.push_back('{mem_addr_o, mem_wr_size_o, mem_wr_data_o});
      end
      if (resp_valid_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc >= 0) chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            chk("resp_rdata", resp_rdata_o, e.data);
            chk("resp_err", 64'(resp_err_o), 64'(e.err));
            last_rdata = resp_rdata_o;
            last_err   = resp_err_o;
            last_cyc   = cyc;
         end
      end else if (exp_q.size() > 0 && exp_q[0].cyc >= 0 && cyc > exp_q[0].cyc) begin
         chk("resp_missing", 64'(cyc), 64'(exp_q[0].cyc));
         void'(exp_q.pop_front());
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      ref_mem[a] = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic set_req(input bit st, input int sz, input bit sg,
                          input logic [63:0] addr, input logic [63:0] wd);
      req_store_i  = st;
      req_size_i   = 2'(sz);
      req_signed_i = sg;
      req_addr_i   = addr;
      req_wdata_i  = wd;
   endtask

   // Registers the expectation and updates the reference image for stores.
   task automatic expect_req(input bit st, input int sz, input bit sg,
                             input logic [63:0] addr, input logic [63:0] wd, output int acc);
      exp_t e;
      e   = model(st, sz, sg, addr, !mem_busy_i);
      acc = cyc;
      if (e.cyc >= 0) e.cyc = cyc + e.cyc;
      exp_q.push_back(e);
      if (st && !e.err)
         for (int i = 0; i < (1 << sz); i++) ref_mem[16'(addr + 64'(i))] = wd[8*i +: 8];
   endtask

   task automatic issue(input bit st, input int sz, input bit sg,
                        input logic [63:0] addr, input logic [63:0] wd, output int acc);
      int g = 0;
      @(negedge clk);
      while (!req_ready_o && g < 100) begin @(negedge clk); g++; end
      if (!req_ready_o) chk("ready_timeout", 64'd0, 64'd1);
      set_req(st, sz, sg, addr, wd);
      req_valid_i = 1'b1;
      expect_req(st, sz, sg, addr, wd, acc);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
   endtask

   task automatic wait_done();
      int g = 0;
      while (exp_q.size() != 0 && g < 300) begin @(negedge clk); g++; end
      if (exp_q.size() != 0) begin
         chk("resp_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   typedef struct { bit st; int sz; bit sg; logic [63:0] addr; logic [63:0] wd; } vec_t;
   vec_t vecs [12];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc2;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
      chk("rst_resp_rdata", resp_rdata_o, 64'd0);
      chk("rst_resp_err", 64'(resp_err_o), 64'd0);
      chk("rst_rd_en", 64'(mem_rd_en_o), 64'd0);
      chk("rst_wr_en", 64'(mem_wr_en_o), 64'd0);
      chk("rst_mem_addr", mem_addr_o, 64'd0);
      chk("rst_wr_size", 64'(mem_wr_size_o), 64'd0);
      chk("rst_wr_data", mem_wr_data_o, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 64'(req_ready_o), 64'd1);

      preload(16'h0010, 8'h80);
      preload(16'h0020, 8'h01);
      preload(16'h0021, 8'h02);
      preload(16'h0022, 8'h03);
      preload(16'h0023, 8'hF4);
      preload(16'hFFFF, 8'h7E);

      // unsigned load B
      rd_log.delete();
      issue(1'b0, 0, 1'b0, 64'h10, 64'h0, acc);
      wait_done();
      chk("ldB_rdata", last_rdata, 64'h80);
      chk("ldB_lat", 64'(last_cyc - acc), 64'd4);
      chk("ldB_rd_count", 64'(rd_log.size()), 64'd1);
      if (rd_log.size() > 0) chk("ldB_rd_addr", rd_log[0].addr, 64'h10);

      // signed load W
      rd_log.delete();
      issue(1'b0, 2, 1'b1, 64'h20, 64'h0, acc);
      wait_done();
      chk("ldW_rdata", last_rdata, 64'hFFFF_FFFF_F403_0201);
      chk("ldW_lat", 64'(last_cyc - acc), 64'd13);
      chk("ldW_rd_count", 64'(rd_log.size()), 64'd4);
      for (int k = 0; k < rd_log.size() && k < 4; k++) begin
         chk("ldW_rd_addr", rd_log[k].addr, 64'h20 + 64'(k));
         chk("ldW_rd_spacing", 64'(rd_log[k].cyc - rd_log[0].cyc), 64'(3 * k));
      end

      // store D then load D
      wr_log.delete();
      issue(1'b1, 3, 1'b0, 64'h100, 64'h1122_3344_5566_7788, acc);
      wait_done();
      chk("stD_lat", 64'(last_cyc - acc), 64'd11);
      chk("stD_rdata", last_rdata, 64'd0);
      chk("stD_wr_count", 64'(wr_log.size()), 64'd1);
      if (wr_log.size() > 0) begin
         chk("stD_wr_addr", wr_log[0].addr, 64'h100);
         chk("stD_wr_size", 64'(wr_log[0].size), 64'd7);
         chk("stD_wr_data", wr_log[0].data, 64'h1122_3344_5566_7788);
      end
      issue(1'b0, 3, 1'b0, 64'h100, 64'h0, acc);
      wait_done();
      chk("ldD_rdata", last_rdata, 64'h1122_3344_5566_7788);
      chk("ldD_lat", 64'(last_cyc - acc), 64'd25);

      // model-checked patterns, including range boundaries
      vecs[0]  = '{1'b0, 1, 1'b1, 64'h22, 64'h0};
      vecs[1]  = '{1'b0, 1, 1'b0, 64'h22, 64'h0};
      vecs[2]  = '{1'b0, 0, 1'b1, 64'h10, 64'h0};
      vecs[3]  = '{1'b0, 2, 1'b0, 64'h20, 64'h0};
      vecs[4]  = '{1'b1, 2, 1'b1, 64'h300, 64'hCAFE_BABE_DEAD_BEEF};
      vecs[5]  = '{1'b0, 2, 1'b1, 64'h300, 64'h0};
      vecs[6]  = '{1'b0, 0, 1'b0, 64'hFFFF, 64'h0};
      vecs[7]  = '{1'b0, 3, 1'b0, 64'hFFF8, 64'h0};
      vecs[8]  = '{1'b0, 1, 1'b0, 64'hFFFF, 64'h0};
      vecs[9]  = '{1'b0, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      vecs[10] = '{1'b1, 1, 1'b0, 64'hFFFF, 64'h1234};
      vecs[11] = '{1'b0, 3, 1'b1, 64'hFFF9, 64'h0};
      for (int v = 0; v < 12; v++) begin
         rd_log.delete();
         wr_log.delete();
         issue(vecs[v].st, vecs[v].sz, vecs[v].sg, vecs[v].addr, vecs[v].wd, acc);
         wait_done();
         if (v >= 8) begin
            chk("err_flag", 64'(last_err), 64'd1);
            chk("err_lat", 64'(last_cyc - acc), 64'd1);
            chk("err_no_mem", 64'(rd_log.size() + wr_log.size()), 64'd0);
         end
      end
      chk("ldH_signed_lit", 64'(model(1'b0, 1, 1'b1, 64'h22, 1'b1).data), 64'hFFFF_FFFF_FFFF_F403);
      chk("ldW_after_stW_lit", 64'(model(1'b0, 2, 1'b1, 64'h300, 1'b1).data), 64'hFFFF_FFFF_DEAD_BEEF);

      // reset while waiting on a load byte; memory stays busy across reset
      rd_extra = 4;
      issue(1'b0, 3, 1'b0, 64'h100, 64'h0, acc);
      @(posedge clk); #1;
      rd_extra = 0;
      rst = 1'b0;
      exp_q.delete();
      rd_log.delete();
      chk("mid_rst_ready", 64'(req_ready_o), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      issue(1'b0, 0, 1'b0, 64'h10, 64'h0, acc);
      wait_done();
      chk("post_rst_rdata", last_rdata, 64'h80);
      chk("post_rst_lat", 64'(last_cyc - acc), 64'd8);
      chk("post_rst_rd_count", 64'(rd_log.size()), 64'd1);
      if (rd_log.size() > 0) begin
         chk("post_rst_rd_wait", 64'(rd_log[0].cyc - acc), 64'd5);
         chk("post_rst_rd_addr", rd_log[0].addr, 64'h10);
      end

      // request held high across a store: next one taken in the following IDLE cycle
      @(negedge clk);
      set_req(1'b1, 0, 1'b0, 64'h200, 64'h5A);
      req_valid_i = 1'b1;
      expect_req(1'b1, 0, 1'b0, 64'h200, 64'h5A, acc);
      @(posedge clk); #1;
      set_req(1'b0, 0, 1'b0, 64'h200, 64'h0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("b2b_ready_low", 64'(req_ready_o), 64'd0);
      end
      @(negedge clk);
      chk("b2b_ready_idle", 64'(req_ready_o), 64'd1);
      expect_req(1'b0, 0, 1'b0, 64'h200, 64'h0, acc2);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      chk("b2b_accepted", 64'(mem_rd_en_o), 64'd1);
      wait_done();
      chk("b2b_rdata", last_rdata, 64'h5A);
      chk("b2b_lat", 64'(last_cyc - acc), 64'd9);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
